// File: rtl/idex_stage_reg_pkg.sv
// Shared pipeline definitions: register-zero specifier, ALU op classes and the
// control bundle that ID/EX carries, including its all-zero bubble value.
package idex_stage_reg_pkg;

  localparam logic [4:0] REG_ZERO = 5'd0;
  localparam int         ALUOP_W  = 2;

  typedef enum logic [ALUOP_W-1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_SUB   = 2'b01,
    ALUOP_FUNCT = 2'b10,
    ALUOP_IMM   = 2'b11
  } aluop_e;

  typedef struct packed {
    logic   regwrite;
    logic   memread;
    logic   memwrite;
    logic   memtoreg;
    logic   alusrc;
    logic   regdst;
    aluop_e aluop;
  } ctrl_t;

  localparam ctrl_t CTRL_BUBBLE = '{
    regwrite: 1'b0,
    memread:  1'b0,
    memwrite: 1'b0,
    memtoreg: 1'b0,
    alusrc:   1'b0,
    regdst:   1'b0,
    aluop:    ALUOP_ADD
  };

endpackage

// File: rtl/idex_stage_reg_load_use_detect.sv
// Flags a load in EX whose destination is read by the instruction in ID.
// Rs and Rt are both compared regardless of whether ID actually reads Rt.
module load_use_detect
  import idex_stage_reg_pkg::*;
(
  input  logic       idex_valid,
  input  logic       idex_memread,
  input  logic [4:0] idex_rt,
  input  logic       id_valid,
  input  logic [4:0] id_rs,
  input  logic [4:0] id_rt,
  output logic       hz
);

  assign hz = idex_valid & idex_memread & (idex_rt != REG_ZERO) & id_valid &
              ((idex_rt == id_rs) | (idex_rt == id_rt));

endmodule

// File: rtl/idex_stage_reg.sv
// ID/EX pipeline register with load-use stall, branch flush, EX hold and a
// saturating count of load-use bubbles.
module idex_stage_reg
  import idex_stage_reg_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  input  logic [4:0]        id_rs,
  input  logic [4:0]        id_rt,
  input  logic [4:0]        id_rd,
  input  logic [DATA_W-1:0] id_rdata1,
  input  logic [DATA_W-1:0] id_rdata2,
  input  logic [DATA_W-1:0] id_imm,
  input  logic              id_regwrite,
  input  logic              id_memread,
  input  logic              id_memwrite,
  input  logic              id_memtoreg,
  input  logic              id_alusrc,
  input  logic              id_regdst,
  input  logic [1:0]        id_aluop,
  input  logic              flush,
  input  logic              ex_hold,
  output logic              idex_valid,
  output logic [4:0]        idex_rs,
  output logic [4:0]        idex_rt,
  output logic [4:0]        idex_rd,
  output logic [DATA_W-1:0] idex_rdata1,
  output logic [DATA_W-1:0] idex_rdata2,
  output logic [DATA_W-1:0] idex_imm,
  output logic              idex_regwrite,
  output logic              idex_memread,
  output logic              idex_memwrite,
  output logic              idex_memtoreg,
  output logic              idex_alusrc,
  output logic              idex_regdst,
  output logic [1:0]        idex_aluop,
  output logic              stall,
  output logic [CNT_W-1:0]  stall_count
);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
  endfunction

  logic                     valid_q,  valid_d;
  logic [4:0]               rs_q,     rs_d;
  logic [4:0]               rt_q,     rt_d;
  logic [4:0]               rd_q,     rd_d;
  logic signed [DATA_W-1:0] rdata1_q, rdata1_d;
  logic signed [DATA_W-1:0] rdata2_q, rdata2_d;
  logic signed [DATA_W-1:0] imm_q,    imm_d;
  ctrl_t                    ctrl_q,   ctrl_d;
  logic [CNT_W-1:0]         cnt_q,    cnt_d;
  ctrl_t                    id_ctrl;
  logic                     hz;

  assign id_ctrl = '{
    regwrite: id_regwrite,
    memread:  id_memread,
    memwrite: id_memwrite,
    memtoreg: id_memtoreg,
    alusrc:   id_alusrc,
    regdst:   id_regdst,
    aluop:    aluop_e'(id_aluop)
  };

  load_use_detect u_detect (
    .idex_valid   (valid_q),
    .idex_memread (ctrl_q.memread),
    .idex_rt      (rt_q),
    .id_valid     (id_valid),
    .id_rs        (id_rs),
    .id_rt        (id_rt),
    .hz           (hz)
  );

  // A flushed ID instruction is dropped rather than replayed, so flush masks the hazard stall.
  assign stall = ~rst & (ex_hold | (hz & ~flush));

  always_comb begin
    valid_d  = valid_q;
    rs_d     = rs_q;
    rt_d     = rt_q;
    rd_d     = rd_q;
    rdata1_d = rdata1_q;
    rdata2_d = rdata2_q;
    imm_d    = imm_q;
    ctrl_d   = ctrl_q;
    cnt_d    = cnt_q;
    if (!ex_hold) begin
      if (flush || hz) begin
        valid_d  = 1'b0;
        rs_d     = REG_ZERO;
        rt_d     = REG_ZERO;
        rd_d     = REG_ZERO;
        rdata1_d = '0;
        rdata2_d = '0;
        imm_d    = '0;
        ctrl_d   = CTRL_BUBBLE;
      end else begin
        valid_d  = id_valid;
        rs_d     = id_rs;
        rt_d     = id_rt;
        rd_d     = id_rd;
        rdata1_d = id_rdata1;
        rdata2_d = id_rdata2;
        imm_d    = id_imm;
        ctrl_d   = id_ctrl;
      end
      if (hz && !flush) cnt_d = sat_inc(cnt_q);
    end
  end

  // ID -> EX stage boundary
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q  <= 1'b0;
      rs_q     <= REG_ZERO;
      rt_q     <= REG_ZERO;
      rd_q     <= REG_ZERO;
      rdata1_q <= '0;
      rdata2_q <= '0;
      imm_q    <= '0;
      ctrl_q   <= CTRL_BUBBLE;
      cnt_q    <= '0;
    end else begin
      valid_q  <= valid_d;
      rs_q     <= rs_d;
      rt_q     <= rt_d;
      rd_q     <= rd_d;
      rdata1_q <= rdata1_d;
      rdata2_q <= rdata2_d;
      imm_q    <= imm_d;
      ctrl_q   <= ctrl_d;
      cnt_q    <= cnt_d;
    end
  end

  assign idex_valid    = valid_q;
  assign idex_rs       = rs_q;
  assign idex_rt       = rt_q;
  assign idex_rd       = rd_q;
  assign idex_rdata1   = rdata1_q;
  assign idex_rdata2   = rdata2_q;
  assign idex_imm      = imm_q;
  assign idex_regwrite = ctrl_q.regwrite;
  assign idex_memread  = ctrl_q.memread;
  assign idex_memwrite = ctrl_q.memwrite;
  assign idex_memtoreg = ctrl_q.memtoreg;
  assign idex_alusrc   = ctrl_q.alusrc;
  assign idex_regdst   = ctrl_q.regdst;
  assign idex_aluop    = ctrl_q.aluop;
  assign stall_count   = cnt_q;

endmodule

// File: tb/tb_idex_stage_reg.sv
// Directed bench for idex_stage_reg: a default instance plus a CNT_W=2 instance
// on the same inputs to exercise counter saturation.
module tb_idex_stage_reg;

  logic        clk = 1'b0;
  logic        rst;
  logic        id_valid;
  logic [4:0]  id_rs, id_rt, id_rd;
  logic [31:0] id_rdata1, id_rdata2, id_imm;
  logic        id_regwrite, id_memread, id_memwrite, id_memtoreg, id_alusrc, id_regdst;
  logic [1:0]  id_aluop;
  logic        flush, ex_hold;

  logic        idex_valid;
  logic [4:0]  idex_rs, idex_rt, idex_rd;
  logic [31:0] idex_rdata1, idex_rdata2, idex_imm;
  logic        idex_regwrite, idex_memread, idex_memwrite, idex_memtoreg, idex_alusrc, idex_regdst;
  logic [1:0]  idex_aluop;
  logic        stall;
  logic [15:0] stall_count;

  logic        s_valid;
  logic [4:0]  s_rs, s_rt, s_rd;
  logic [31:0] s_rdata1, s_rdata2, s_imm;
  logic        s_regwrite, s_memread, s_memwrite, s_memtoreg, s_alusrc, s_regdst;
  logic [1:0]  s_aluop;
  logic        s_stall;
  logic [1:0]  s_count;

  int total = 0;
  int bad   = 0;

  wire [7:0] ctrl_o = {idex_regwrite, idex_memread, idex_memwrite, idex_memtoreg,
                       idex_alusrc, idex_regdst, idex_aluop};

  always #5 clk = ~clk;

  idex_stage_reg dut (
    .clk(clk), .rst(rst), .id_valid(id_valid),
    .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
    .id_rdata1(id_rdata1), .id_rdata2(id_rdata2), .id_imm(id_imm),
    .id_regwrite(id_regwrite), .id_memread(id_memread), .id_memwrite(id_memwrite),
    .id_memtoreg(id_memtoreg), .id_alusrc(id_alusrc), .id_regdst(id_regdst),
    .id_aluop(id_aluop), .flush(flush), .ex_hold(ex_hold),
    .idex_valid(idex_valid), .idex_rs(idex_rs), .idex_rt(idex_rt), .idex_rd(idex_rd),
    .idex_rdata1(idex_rdata1), .idex_rdata2(idex_rdata2), .idex_imm(idex_imm),
    .idex_regwrite(idex_regwrite), .idex_memread(idex_memread), .idex_memwrite(idex_memwrite),
    .idex_memtoreg(idex_memtoreg), .idex_alusrc(idex_alusrc), .idex_regdst(idex_regdst),
    .idex_aluop(idex_aluop), .stall(stall), .stall_count(stall_count)
  );

  idex_stage_reg #(.DATA_W(32), .CNT_W(2)) dut_sat (
    .clk(clk), .rst(rst), .id_valid(id_valid),
    .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
    .id_rdata1(id_rdata1), .id_rdata2(id_rdata2), .id_imm(id_imm),
    .id_regwrite(id_regwrite), .id_memread(id_memread), .id_memwrite(id_memwrite),
    .id_memtoreg(id_memtoreg), .id_alusrc(id_alusrc), .id_regdst(id_regdst),
    .id_aluop(id_aluop), .flush(flush), .ex_hold(ex_hold),
    .idex_valid(s_valid), .idex_rs(s_rs), .idex_rt(s_rt), .idex_rd(s_rd),
    .idex_rdata1(s_rdata1), .idex_rdata2(s_rdata2), .idex_imm(s_imm),
    .idex_regwrite(s_regwrite), .idex_memread(s_memread), .idex_memwrite(s_memwrite),
    .idex_memtoreg(s_memtoreg), .idex_alusrc(s_alusrc), .idex_regdst(s_regdst),
    .idex_aluop(s_aluop), .stall(s_stall), .stall_count(s_count)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // ctrl bits ordered {regwrite, memread, memwrite, memtoreg, alusrc, regdst}
  task automatic set_id(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                        input logic [4:0] rd, input logic [31:0] d1, input logic [31:0] d2,
                        input logic [31:0] imm, input logic [5:0] c, input logic [1:0] op);
    id_valid  = v;
    id_rs     = rs;
    id_rt     = rt;
    id_rd     = rd;
    id_rdata1 = d1;
    id_rdata2 = d2;
    id_imm    = imm;
    {id_regwrite, id_memread, id_memwrite, id_memtoreg, id_alusrc, id_regdst} = c;
    id_aluop  = op;
  endtask

  task automatic test_reset();
    rst = 1'b1; ex_hold = 1'b1; flush = 1'b0;
    set_id(1'b1, 5'd1, 5'd2, 5'd3, 32'h5, 32'h6, 32'h7, 6'b111111, 2'b11);
    #1;
    total++; if (stall !== 1'b0) begin bad++; $display("FAIL rst_stall_forced got=%0h want=0", stall); end
    step();
    total++; if ({idex_valid, ctrl_o} !== 9'h0) begin bad++; $display("FAIL rst_ctrl got=%0h want=0", {idex_valid, ctrl_o}); end
    total++; if ({idex_rs, idex_rt, idex_rd} !== 15'h0) begin bad++; $display("FAIL rst_spec got=%0h want=0", {idex_rs, idex_rt, idex_rd}); end
    total++; if ({idex_rdata1, idex_rdata2, idex_imm} !== 96'h0) begin bad++; $display("FAIL rst_data got=%0h want=0", {idex_rdata1, idex_rdata2, idex_imm}); end
    total++; if (stall_count !== 16'd0 || s_count !== 2'd0) begin bad++; $display("FAIL rst_count got=%0d/%0d want=0/0", stall_count, s_count); end
    rst = 1'b0; ex_hold = 1'b0;
  endtask

  task automatic test_pass_through();
    set_id(1'b1, 5'd2, 5'd3, 5'd4, 32'h11, 32'h22, 32'h33, 6'b100000, 2'b10);
    #1;
    total++; if (stall !== 1'b0) begin bad++; $display("FAIL pt_stall0 got=%0h want=0", stall); end
    step();
    total++; if ({idex_rs, idex_rt, idex_rd} !== {5'd2, 5'd3, 5'd4}) begin bad++; $display("FAIL pt_spec got=%0h want=%0h", {idex_rs, idex_rt, idex_rd}, {5'd2, 5'd3, 5'd4}); end
    total++; if ({idex_rdata1, idex_rdata2, idex_imm} !== {32'h11, 32'h22, 32'h33}) begin bad++; $display("FAIL pt_data got=%0h want=112233", {idex_rdata1, idex_rdata2, idex_imm}); end
    total++; if ({idex_valid, ctrl_o} !== 9'h182) begin bad++; $display("FAIL pt_ctrl got=%0h want=182", {idex_valid, ctrl_o}); end
    set_id(1'b1, 5'd5, 5'd6, 5'd7, 32'h44, 32'h55, 32'h66, 6'b100001, 2'b10);
    #1;
    total++; if (stall !== 1'b0) begin bad++; $display("FAIL pt_stall1 got=%0h want=0", stall); end
    step();
    total++; if (idex_rs !== 5'd5 || idex_rdata1 !== 32'h44 || ctrl_o !== 8'h86) begin bad++; $display("FAIL pt_second got=%0h/%0h/%0h want=5/44/86", idex_rs, idex_rdata1, ctrl_o); end
  endtask

  task automatic test_load_use();
    set_id(1'b1, 5'd1, 5'd8, 5'd0, 32'h100, 32'h0, 32'h4, 6'b110110, 2'b00);
    step();
    total++; if (idex_rt !== 5'd8 || ctrl_o !== 8'hD8) begin bad++; $display("FAIL lu_lw got=%0h/%0h want=8/d8", idex_rt, ctrl_o); end
    set_id(1'b1, 5'd8, 5'd9, 5'd10, 32'h200, 32'h300, 32'h0, 6'b100001, 2'b10);
    #1;
    total++; if (stall !== 1'b1) begin bad++; $display("FAIL lu_stall got=%0h want=1", stall); end
    step();
    total++; if ({idex_valid, ctrl_o} !== 9'h0) begin bad++; $display("FAIL lu_bubble_ctrl got=%0h want=0", {idex_valid, ctrl_o}); end
    total++; if ({idex_rs, idex_rt, idex_rdata1, idex_imm} !== 74'h0) begin bad++; $display("FAIL lu_bubble_fields got=%0h want=0", {idex_rs, idex_rt, idex_rdata1, idex_imm}); end
    total++; if (stall_count !== 16'd1 || s_count !== 2'd1) begin bad++; $display("FAIL lu_count got=%0d/%0d want=1/1", stall_count, s_count); end
    total++; if (stall !== 1'b0) begin bad++; $display("FAIL lu_stall_drop got=%0h want=0", stall); end
    step();
    total++; if (idex_valid !== 1'b1 || idex_rs !== 5'd8 || idex_rdata1 !== 32'h200) begin bad++; $display("FAIL lu_replay got=%0h/%0h/%0h want=1/8/200", idex_valid, idex_rs, idex_rdata1); end
    // Rt-side dependency, and an invalid ID slot that must not stall
    set_id(1'b1, 5'd3, 5'd12, 5'd0, 32'h0, 32'h0, 32'h8, 6'b110110, 2'b00);
    step();
    set_id(1'b0, 5'd12, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0, 6'b100001, 2'b10);
    #1;
    total++; if (stall !== 1'b0) begin bad++; $display("FAIL lu_idinvalid got=%0h want=0", stall); end
    set_id(1'b1, 5'd4, 5'd12, 5'd5, 32'h0, 32'h0, 32'h0, 6'b100001, 2'b10);
    #1;
    total++; if (stall !== 1'b1) begin bad++; $display("FAIL lu_rt_stall got=%0h want=1", stall); end
    step();
    total++; if (idex_valid !== 1'b0 || stall_count !== 16'd2 || s_count !== 2'd2) begin bad++; $display("FAIL lu_rt_bubble got=%0h/%0d/%0d want=0/2/2", idex_valid, stall_count, s_count); end
  endtask

  task automatic test_load_zero();
    set_id(1'b1, 5'd1, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0, 6'b110110, 2'b00);
    step();
    total++; if (idex_memread !== 1'b1 || idex_rt !== 5'd0) begin bad++; $display("FAIL lz_lw got=%0h/%0h want=1/0", idex_memread, idex_rt); end
    set_id(1'b1, 5'd0, 5'd0, 5'd3, 32'h0, 32'h0, 32'h0, 6'b100001, 2'b10);
    #1;
    total++; if (stall !== 1'b0) begin bad++; $display("FAIL lz_stall got=%0h want=0", stall); end
    step();
    total++; if (idex_valid !== 1'b1 || idex_rd !== 5'd3 || stall_count !== 16'd2) begin bad++; $display("FAIL lz_nobubble got=%0h/%0h/%0d want=1/3/2", idex_valid, idex_rd, stall_count); end
  endtask

  task automatic test_hz_flush();
    set_id(1'b1, 5'd1, 5'd8, 5'd0, 32'h100, 32'h0, 32'h4, 6'b110110, 2'b00);
    step();
    set_id(1'b1, 5'd7, 5'd8, 5'd2, 32'h9, 32'h9, 32'h9, 6'b100001, 2'b10);
    flush = 1'b1;
    #1;
    total++; if (stall !== 1'b0) begin bad++; $display("FAIL hf_stall got=%0h want=0", stall); end
    step();
    total++; if ({idex_valid, ctrl_o} !== 9'h0 || idex_rdata1 !== 32'h0) begin bad++; $display("FAIL hf_bubble got=%0h/%0h want=0/0", {idex_valid, ctrl_o}, idex_rdata1); end
    total++; if (stall_count !== 16'd2 || s_count !== 2'd2) begin bad++; $display("FAIL hf_count got=%0d/%0d want=2/2", stall_count, s_count); end
    flush = 1'b0;
  endtask

  task automatic test_hz_hold();
    set_id(1'b1, 5'd1, 5'd8, 5'd0, 32'hAA, 32'h0, 32'h4, 6'b110110, 2'b00);
    step();
    set_id(1'b1, 5'd8, 5'd0, 5'd2, 32'h1, 32'h2, 32'h3, 6'b100001, 2'b10);
    ex_hold = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      total++; if (stall !== 1'b1) begin bad++; $display("FAIL hh_stall[%0d] got=%0h want=1", i, stall); end
      step();
      total++; if (idex_rt !== 5'd8 || idex_rdata1 !== 32'hAA || ctrl_o !== 8'hD8 || stall_count !== 16'd2) begin
        bad++; $display("FAIL hh_frozen[%0d] got=%0h/%0h/%0h/%0d want=8/aa/d8/2", i, idex_rt, idex_rdata1, ctrl_o, stall_count);
      end
    end
    ex_hold = 1'b0;
    #1;
    total++; if (stall !== 1'b1) begin bad++; $display("FAIL hh_release_stall got=%0h want=1", stall); end
    step();
    total++; if (idex_valid !== 1'b0 || stall_count !== 16'd3 || s_count !== 2'd3) begin bad++; $display("FAIL hh_bubble got=%0h/%0d/%0d want=0/3/3", idex_valid, stall_count, s_count); end
    total++; if (stall !== 1'b0) begin bad++; $display("FAIL hh_after got=%0h want=0", stall); end
  endtask

  task automatic test_flush_in_hold();
    set_id(1'b1, 5'd5, 5'd6, 5'd7, 32'h77, 32'h0, 32'h0, 6'b100001, 2'b10);
    step();
    ex_hold = 1'b1; flush = 1'b1;
    set_id(1'b1, 5'd9, 5'd9, 5'd9, 32'h99, 32'h99, 32'h99, 6'b100001, 2'b10);
    #1;
    total++; if (stall !== 1'b1) begin bad++; $display("FAIL fh_stall got=%0h want=1", stall); end
    step();
    total++; if (idex_valid !== 1'b1 || idex_rs !== 5'd5 || idex_rdata1 !== 32'h77) begin bad++; $display("FAIL fh_held got=%0h/%0h/%0h want=1/5/77", idex_valid, idex_rs, idex_rdata1); end
    ex_hold = 1'b0;
    #1;
    total++; if (stall !== 1'b0) begin bad++; $display("FAIL fh_stall_rel got=%0h want=0", stall); end
    step();
    total++; if (idex_valid !== 1'b0 || idex_rs !== 5'd0 || stall_count !== 16'd3) begin bad++; $display("FAIL fh_flushed got=%0h/%0h/%0d want=0/0/3", idex_valid, idex_rs, stall_count); end
    flush = 1'b0;
  endtask

  task automatic test_saturation();
    for (int i = 0; i < 3; i++) begin
      set_id(1'b1, 5'd1, 5'd8, 5'd0, 32'h0, 32'h0, 32'h0, 6'b110110, 2'b00);
      step();
      set_id(1'b1, 5'd8, 5'd8, 5'd2, 32'h0, 32'h0, 32'h0, 6'b100001, 2'b10);
      step();
      total++; if (s_count !== 2'd3) begin bad++; $display("FAIL sat_hold[%0d] got=%0d want=3", i, s_count); end
    end
    total++; if (stall_count !== 16'd6) begin bad++; $display("FAIL sat_wide got=%0d want=6", stall_count); end
  endtask

  task automatic test_reset_mid();
    set_id(1'b1, 5'd1, 5'd8, 5'd0, 32'h5, 32'h0, 32'h0, 6'b110110, 2'b00);
    step();
    set_id(1'b1, 5'd8, 5'd0, 5'd2, 32'h6, 32'h0, 32'h0, 6'b100001, 2'b10);
    ex_hold = 1'b1;
    #1;
    total++; if (stall !== 1'b1) begin bad++; $display("FAIL rm_pre got=%0h want=1", stall); end
    rst = 1'b1;
    #1;
    total++; if (stall !== 1'b0) begin bad++; $display("FAIL rm_forced got=%0h want=0", stall); end
    step();
    total++; if ({idex_valid, ctrl_o, idex_rs, idex_rt, idex_rd, idex_rdata1} !== 56'h0) begin bad++; $display("FAIL rm_regs got=%0h want=0", {idex_valid, ctrl_o, idex_rs, idex_rt, idex_rd, idex_rdata1}); end
    total++; if (stall_count !== 16'd0 || s_count !== 2'd0) begin bad++; $display("FAIL rm_count got=%0d/%0d want=0/0", stall_count, s_count); end
    rst = 1'b0; ex_hold = 1'b0;
    #1;
    total++; if (stall !== 1'b0) begin bad++; $display("FAIL rm_after got=%0h want=0", stall); end
    step();
    total++; if (idex_valid !== 1'b1 || idex_rs !== 5'd8 || idex_rdata1 !== 32'h6) begin bad++; $display("FAIL rm_resume got=%0h/%0h/%0h want=1/8/6", idex_valid, idex_rs, idex_rdata1); end
  endtask

  initial begin
    test_reset();
    test_pass_through();
    test_load_use();
    test_load_zero();
    test_hz_flush();
    test_hz_hold();
    test_flush_in_hold();
    test_saturation();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
